// File: rtl/ahb_apb_master.sv
// ahb_apb_master
//   AHB-Lite slave front end of the AHB-to-APB bridge. Each accepted
//   NONSEQ/SEQ transfer becomes one APB SETUP/ACCESS transfer, and the AHB
//   data phase is held with HREADYOUT=0 until the APB side completes.
//   The APB side runs on HCLK. All outputs are registered.
//
//   Optional feature macro: APB_PSLVERR_EN
//     defined   : PSLVERR sampled at ACCESS & PREADY; 1 gives a two-cycle
//                 AHB ERROR response (ERR1 then ERR2).
//     undefined : PSLVERR ignored, HRESP stays 0, ERR1/ERR2 never entered.
//
//   Ports
//     HCLK, HRESETn            clock, async active-low reset
//     HSEL, HADDR, HTRANS,     AHB-Lite address/control phase
//     HWRITE, HREADY
//     HWDATA                   AHB write data (data phase)
//     HREADYOUT, HRESP, HRDATA AHB data-phase response
//     PSEL, PENABLE, PWRITE,   APB master request
//     PADDR, PWDATA
//     PRDATA, PREADY, PSLVERR  APB completer response
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no transfer pending, zero-wait OKAY, accepts new transfer
//   WLATCH | write accepted, capture HWDATA into PWDATA
//   SETUP  | APB setup phase (PSEL=1, PENABLE=0)
//   ACCESS | APB access phase, waits for PREADY
//   ERR1   | first ERROR cycle (HREADYOUT=0, HRESP=1)
//   ERR2   | second ERROR cycle (HREADYOUT=1, HRESP=1), may accept

module ahb_apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WLATCH = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    logic [2:0] state;
    logic       accept;
    logic       apb_err;

    // HTRANS[1] covers both NONSEQ and SEQ; BUSY/IDLE never start a transfer.
    assign accept = HSEL & HTRANS[1] & HREADY;

`ifdef APB_PSLVERR_EN
    assign apb_err = PSLVERR;
    logic unused_in;
    assign unused_in = ^{HADDR[1:0], HTRANS[0]};
`else
    assign apb_err = 1'b0;
    logic unused_in;
    assign unused_in = ^{HADDR[1:0], HTRANS[0], PSLVERR};
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            case (state)
                // ERR2 behaves like IDLE for acceptance; its HRESP=1 is
                // already registered, so only the next-cycle values matter.
                ST_IDLE, ST_ERR2: begin
                    HRESP     <= 1'b0;
                    HREADYOUT <= 1'b1;
                    state     <= ST_IDLE;
                    if (accept) begin
                        PADDR     <= {HADDR[ADDR_WIDTH-1:2], 2'b00};
                        PWRITE    <= HWRITE;
                        HREADYOUT <= 1'b0;
                        if (HWRITE) begin
                            state <= ST_WLATCH;
                        end else begin
                            state <= ST_SETUP;
                            PSEL  <= 1'b1;
                        end
                    end
                end
                ST_WLATCH: begin
                    PWDATA <= HWDATA;
                    PSEL   <= 1'b1;
                    state  <= ST_SETUP;
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (!PWRITE) begin
                            HRDATA <= PRDATA;
                        end
                        if (apb_err) begin
                            state <= ST_ERR1;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            HREADYOUT <= 1'b1;
                        end
                    end
                end
                ST_ERR1: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                    state     <= ST_ERR2;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule
